// File: rtl/burst_len_rx.sv
// Beat/end-marker pulse receiver: counts `s` beats per burst and, on `g`,
// presents the saturated burst length on a one-deep valid/ready result register.
module burst_len_rx #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s,
  input  logic          g,
  input  logic          len_rdy,
  input  logic          clr,
  output logic          busy,
  output logic          len_vld,
  output logic [CW-1:0] len,
  output logic          len_ovf,
  output logic          err,
  output logic          drop
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ovf, ovf_n;
  logic          busy_n, len_vld_n, len_ovf_n, err_n, drop_n;
  logic [CW-1:0] len_n;

  // Count and overflow as they stand once this cycle's beat is included.
  logic [CW-1:0] beat_cnt;
  logic          beat_ovf;
  logic          drop_set;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    ovf_n     = ovf;
    len_vld_n = len_vld;
    len_n     = len;
    len_ovf_n = len_ovf;
    drop_set  = 1'b0;
    beat_cnt  = cnt;
    beat_ovf  = ovf;

    if (s) begin
      beat_cnt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
      beat_ovf = ovf | (cnt == CNT_MAX);
    end

    // `cnt`/`ovf` are always zero in IDLE, so the same arithmetic covers
    // both states; `g` closes the burst (including a coincident beat).
    if (g) begin
      state_n = IDLE;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else if (s) begin
      state_n = ACC;
      cnt_n   = beat_cnt;
      ovf_n   = beat_ovf;
    end

    // Result register: a completion into a full, unconsumed slot is lost.
    if (g) begin
      if (len_vld && !len_rdy) begin
        drop_set = 1'b1;
      end else begin
        len_vld_n = 1'b1;
        len_n     = beat_cnt;
        len_ovf_n = beat_ovf;
      end
    end else if (len_vld && len_rdy) begin
      len_vld_n = 1'b0;
    end

    busy_n = (state_n == ACC);
    err_n  = s & g;
    drop_n = drop_set | (drop & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      len_vld <= 1'b0;
      len     <= '0;
      len_ovf <= 1'b0;
      err     <= 1'b0;
      drop    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state   <= state_n;
      cnt     <= cnt_n;
      ovf     <= ovf_n;
      busy    <= busy_n;
      len_vld <= len_vld_n;
      len     <= len_n;
      len_ovf <= len_ovf_n;
      err     <= err_n;
      drop    <= drop_n;
    end
  end

endmodule

// File: tb/tb_burst_len_rx.sv
// Self-checking bench for burst_len_rx (CW=4): directed test-plan steps followed
// by random traffic, all compared against a beat-counting reference model.
module tb_burst_len_rx;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s = 1'b0, g = 1'b0, len_rdy = 1'b0, clr = 1'b0;
  logic          busy, len_vld, len_ovf, err, drop;
  logic [CW-1:0] len;

  int checks = 0;
  int errors = 0;

  // Reference model state: open burst, unbounded beat tally, result slot.
  bit m_open;
  int m_beats;
  bit m_vld;
  int m_len;
  bit m_ovf;
  bit m_err;
  bit m_drop;

  burst_len_rx #(.CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
    .g       (g),
    .len_rdy (len_rdy),
    .clr     (clr),
    .busy    (busy),
    .len_vld (len_vld),
    .len     (len),
    .len_ovf (len_ovf),
    .err     (err),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_beats = 0; m_vld = 0; m_len = 0;
    m_ovf = 0; m_err = 0; m_drop = 0;
  endtask

  // Outcome of one clock edge given the inputs present before it.
  task automatic model_edge(input bit si, gi, ri, ci);
    bit done, lost;
    int total;
    done = gi;
    total = m_beats + (si ? 1 : 0);
    lost = 0;
    m_err = si && gi;
    if (gi) begin
      m_open = 0;
      m_beats = 0;
    end else if (si) begin
      m_open = 1;
      m_beats = total;
    end
    if (done) begin
      if (m_vld && !ri) lost = 1;
      else begin
        m_vld = 1;
        m_len = (total > MAX) ? MAX : total;
        m_ovf = (total > MAX);
      end
    end else if (m_vld && ri) begin
      m_vld = 0;
    end
    m_drop = lost || (m_drop && !ci);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".busy"},    32'(busy),    32'(m_open));
    check({tag, ".len_vld"}, 32'(len_vld), 32'(m_vld));
    check({tag, ".len"},     32'(len),     32'(m_len));
    check({tag, ".len_ovf"}, 32'(len_ovf), 32'(m_ovf));
    check({tag, ".err"},     32'(err),     32'(m_err));
    check({tag, ".drop"},    32'(drop),    32'(m_drop));
  endtask

  task automatic step(input bit si, gi, ri, ci, input string tag);
    s = si; g = gi; len_rdy = ri; clr = ci;
    model_edge(si, gi, ri, ci);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    // Reset: all outputs low while rst_n is asserted.
    model_reset();
    #12;
    compare_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three beats, a gap, then g.
    step(1, 0, 1, 0, "b3_s1");
    check("b3_busy_rise", 32'(busy), 32'd1);
    step(1, 0, 1, 0, "b3_s2");
    step(1, 0, 1, 0, "b3_s3");
    step(0, 0, 1, 0, "b3_gap");
    check("b3_busy_gap", 32'(busy), 32'd1);
    step(0, 1, 1, 0, "b3_g");
    check("b3_len", 32'(len), 32'd3);
    check("b3_vld", 32'(len_vld), 32'd1);
    check("b3_busy_fall", 32'(busy), 32'd0);
    step(0, 0, 1, 0, "b3_done");
    check("b3_vld_fall", 32'(len_vld), 32'd0);

    // Zero-length burst.
    step(0, 1, 1, 0, "zero_g");
    check("zero_len", 32'(len), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    step(0, 0, 1, 0, "zero_done");

    // Saturation: 20 beats on a 4-bit counter, then a 2-beat burst.
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, "sat_s");
    step(0, 1, 1, 0, "sat_g");
    check("sat_len", 32'(len), 32'd15);
    check("sat_ovf", 32'(len_ovf), 32'd1);
    step(1, 0, 1, 0, "post_s1");
    step(1, 0, 1, 0, "post_s2");
    step(0, 1, 1, 0, "post_g");
    check("post_len", 32'(len), 32'd2);
    check("post_ovf", 32'(len_ovf), 32'd0);

    // Full register: burst of 2 held, burst of 5 dropped.
    step(1, 0, 1, 0, "full_flush");
    step(1, 0, 0, 0, "full_a1");
    step(0, 1, 0, 0, "full_ag");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, "full_b");
    step(0, 1, 0, 0, "full_bg");
    check("full_len_held", 32'(len), 32'd2);
    check("full_drop", 32'(drop), 32'd1);
    step(0, 0, 1, 0, "full_consume");
    check("full_consumed", 32'(len_vld), 32'd0);
    step(0, 0, 0, 1, "full_clr");
    check("full_drop_clr", 32'(drop), 32'd0);

    // Completion on the same cycle as a consume.
    step(1, 0, 0, 0, "cc_a1");
    step(0, 1, 0, 0, "cc_ag");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "cc_b");
    step(0, 1, 1, 0, "cc_bg");
    check("cc_len", 32'(len), 32'd3);
    check("cc_vld", 32'(len_vld), 32'd1);
    check("cc_nodrop", 32'(drop), 32'd0);

    // s and g together after one prior beat.
    step(1, 0, 1, 0, "sg_s");
    step(1, 1, 1, 0, "sg_both");
    check("sg_len", 32'(len), 32'd2);
    check("sg_err", 32'(err), 32'd1);
    check("sg_idle", 32'(busy), 32'd0);
    step(0, 0, 1, 0, "sg_after");
    check("sg_err_fall", 32'(err), 32'd0);

    // Asynchronous reset mid-burst, then a single-beat burst.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, "rst_s");
    s = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("rst_mid");
    @(posedge clk); #1;
    compare_all("rst_hold");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    compare_all("rst_rel");
    step(1, 0, 1, 0, "rst_s1");
    step(0, 1, 1, 0, "rst_g");
    check("rst_len", 32'(len), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rs, rg, rr, rc;
      rs = ($urandom_range(0, 99) < 60);
      rg = ($urandom_range(0, 99) < 12);
      rr = ($urandom_range(0, 99) < 65);
      rc = ($urandom_range(0, 99) < 8);
      step(rs, rg, rr, rc, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_len_rx.md
# burst_len_rx

Receiving end of the beat/end-marker pulse protocol. The transmitting FSM emits a one-cycle `s` strobe per active beat and a one-cycle `g` pulse that closes the burst. This block counts the beats of each burst and, on `g`, presents the burst length on a one-deep valid/ready result port, with saturation, protocol-error and drop reporting. It sits on the same clock domain as the transmitter, directly on its registered `s`/`g` outputs.

## Interface
- `CW`, default 8: width of the beat counter and of `len`. Saturation value is 2^CW-1.
- `clk`, input, 1: rising-edge clock. One clock only.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `s`, input, 1: beat strobe; each high cycle is one beat.
- `g`, input, 1: end-of-burst pulse; a high cycle closes the current burst.
- `len_rdy`, input, 1: consumer ready for the result.
- `clr`, input, 1: synchronous clear of the sticky `drop` flag.
- `busy`, output, 1: high while a burst is open (state ACC).
- `len_vld`, output, 1: result valid.
- `len`, output, CW: beat count of the completed burst.
- `len_ovf`, output, 1: the burst exceeded 2^CW-1 beats; `len` is saturated. Qualified by `len_vld`.
- `err`, output, 1: one-cycle pulse on a protocol violation (`s` and `g` high in the same cycle).
- `drop`, output, 1: sticky; a completed result was lost because the result register was full.

## Operation
- Reset: state IDLE; internal counter 0; `busy`, `len_vld`, `len`, `len_ovf`, `err` and `drop` all 0. Reset is asynchronous and may assert mid-burst. A partially counted burst is discarded, with no result and no error reported.
- The FSM has two states, IDLE and ACC. All outputs are registered, with the next value computed on the transition (dff-onTransit style).
- In IDLE:
  - `s` and not `g`: go to ACC; counter becomes 1.
  - `g` and not `s`: zero-length burst; complete with len=0; stay in IDLE.
  - Neither: stay in IDLE.
- In ACC:
  - `s` and not `g`: counter increments; stay in ACC.
  - `g`: complete the burst; go to IDLE; counter returns to 0.
  - Neither: hold.
- `s` and `g` together, in either state: the beat is counted, the burst completes including that beat, and `err` pulses for one cycle. The FSM goes to IDLE.
- Saturation: the counter stops at 2^CW-1. An `s` at saturation sets the internal ovf bit. That bit clears at completion and at reset.
- Completion writes the result register: `len` gets the final count (saturated), `len_ovf` gets the ovf bit, `len_vld` goes to 1.
- Handshake: the result is consumed at the edge where `len_vld` and `len_rdy` are both high. `len_vld` falls at that edge unless a new completion occurs in the same cycle.
- `len`/`len_ovf` stay stable while `len_vld` is high and not consumed.
- Full register:
  - Completion while `len_vld`=1 and `len_rdy`=0: the old result is kept, the new one is discarded, and `drop` is set to 1.
  - Completion in the same cycle as a consume: the new result is loaded with no drop, and `len_vld` stays 1.
- `drop` stays set until `clr` is high at an edge. If `clr` and a new drop event occur in the same cycle, `drop` stays 1 (set wins).
- `len_rdy` and `clr` have no effect on counting.

## Timing
- `g` sampled high at edge N: `len_vld`/`len` are valid after edge N, and `busy` falls after edge N.
- First `s` sampled at edge N: `busy` rises after edge N.
- `err` is high for exactly the one cycle after the offending edge.
- Back-to-back bursts are supported: a `g` followed immediately by an `s` on the next cycle starts a new burst.
- Throughput: one completion per cycle is accepted if `len_rdy` is held high.
- No combinational path from any input to any output.

## Test plan
- Reset, then 3 `s` pulses, a gap, then `g`, with `len_rdy`=1 -> `busy` high for 3 cycles plus the gap; `len_vld`=1 for one cycle with `len`=3, `len_ovf`=0, `err`=0.
- `g` alone while in IDLE -> `len_vld` with `len`=0; `busy` stays 0.
- CW=4, 20 `s` pulses then `g` -> `len`=15, `len_ovf`=1. A following 2-beat burst reports `len`=2, `len_ovf`=0.
- `len_rdy`=0: burst of 2, then burst of 5 -> `len`=2 held, `drop`=1. Raise `len_rdy` -> consumed. Pulse `clr` -> `drop`=0. A completion on the same cycle as a consume loads the new `len` with no drop.
- `s` and `g` together after 1 prior beat -> `len`=2, `err` pulses for 1 cycle, FSM returns to IDLE.
- Assert `rst_n` low mid-burst after 4 beats, then release, then send 1 beat and `g` -> no result for the aborted burst; the next result has `len`=1; all outputs are 0 during reset.
